// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single unified memory port between the instruction-fetch (IF)
// and data-memory (MEM) stages of the pipelined MIPS core.  Every access
// goes through IDLE -> BUSY_I/BUSY_D -> RESP -> IDLE.  A data request wins
// over a fetch request in IDLE.  A streak counter forces fetch to win once
// MAX_DATA_STREAK data grants have been made back-to-back while a fetch was
// waiting.
//
// Optional build macro: MEM_ARB_TIMEOUT_EN
//   defined   -> a BUSY access with no mem_ready for TIMEOUT_CYCLES edges is
//                aborted.  It completes with x_valid=1, x_err=1, x_rdata=0.
//   undefined -> BUSY waits indefinitely and if_err/dm_err are constant 0.
//
// Ports:
//   clock, reset         core clock; synchronous active-high reset
//   if_req/if_addr       fetch read request (held until if_valid)
//   if_gnt/if_valid      one-cycle pulses: accepted / complete
//   if_rdata/if_err      fetched word / aborted flag (with if_valid)
//   dm_req/dm_we         data request; 1 = store word, 0 = load word
//   dm_addr/dm_wdata     data byte address / store data
//   dm_gnt/dm_valid      one-cycle pulses: accepted / complete
//   dm_rdata/dm_err      load data (kept unchanged by stores) / aborted flag
//   mem_req/mem_we       memory access active / write enable
//   mem_addr/mem_wdata   word-aligned address / write data
//   mem_ready/mem_rdata  memory completes this cycle / read data
//   busy                 arbiter is not idle
// All outputs are registered.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_valid,
    output logic [31:0] dm_rdata,
    output logic        dm_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t        state_reg;
    logic [SW-1:0] streak_reg;

    // Byte-lane bits are dropped because the port only moves whole words.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], dm_addr[1:0]};

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // The counter is zero on the first BUSY edge, so a match with
    // TIMEOUT_CYCLES-1 happens on the TIMEOUT_CYCLES-th edge without mem_ready.
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_reg;
    logic          tmo_hit;
    assign tmo_hit = (tmo_reg == TIMEOUT_LAST);
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign if_err = 1'b0;
    assign dm_err = 1'b0;
`endif

    // Arbitration.  Data wins unless the fetch has been passed over
    // MAX_DATA_STREAK times in a row.  The result is used only in IDLE.
    logic pick_data;
    logic pick_fetch;
    always_comb begin
        pick_data  = dm_req && ((streak_reg < STREAK_MAX) || !if_req);
        pick_fetch = if_req && !pick_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            streak_reg <= '0;
            if_gnt     <= 1'b0;
            if_valid   <= 1'b0;
            if_rdata   <= '0;
            dm_gnt     <= 1'b0;
            dm_valid   <= 1'b0;
            dm_rdata   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_reg    <= '0;
            if_err     <= 1'b0;
            dm_err     <= 1'b0;
`endif
        end else begin
            // Grant, valid and error flags are single-cycle pulses.
            if_gnt   <= 1'b0;
            dm_gnt   <= 1'b0;
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            if_err   <= 1'b0;
            dm_err   <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (pick_data) begin
                        state_reg <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= {dm_addr[31:2], 2'b00};
                        mem_wdata <= dm_wdata;
                        dm_gnt    <= 1'b1;
                        busy      <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                        tmo_reg   <= '0;
`endif
                        // A streak only counts while a fetch is waiting.
                        if (if_req) begin
                            if (streak_reg != STREAK_MAX)
                                streak_reg <= streak_reg + 1'b1;
                        end else begin
                            streak_reg <= '0;
                        end
                    end else if (pick_fetch) begin
                        state_reg  <= BUSY_I;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= {if_addr[31:2], 2'b00};
                        mem_wdata  <= '0;
                        if_gnt     <= 1'b1;
                        busy       <= 1'b1;
                        streak_reg <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
                        tmo_reg    <= '0;
`endif
                    end
                end

                BUSY_I, BUSY_D: begin
                    if (mem_ready) begin
                        state_reg <= RESP;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        if (state_reg == BUSY_I) begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_rdata;
                        end else begin
                            dm_valid <= 1'b1;
                            // A store leaves the last load result in place.
                            if (!mem_we)
                                dm_rdata <= mem_rdata;
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state_reg <= RESP;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        if (state_reg == BUSY_I) begin
                            if_valid <= 1'b1;
                            if_err   <= 1'b1;
                            if_rdata <= '0;
                        end else begin
                            dm_valid <= 1'b1;
                            dm_err   <= 1'b1;
                            dm_rdata <= '0;
                        end
                    end else begin
                        tmo_reg <= tmo_reg + 1'b1;
                    end
`endif
                end

                RESP: begin
                    // Gives the requester one cycle to drop or change its
                    // request before arbitration runs again.
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end

                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed testbench for mem_port_arbiter.  A transaction-level model
// (phase / owner / streak kept as plain integers) predicts every output each
// cycle, and one compare process checks the DUT against it on the falling
// edge.  Directed sequences add hand-computed literal checks.
// Define MEM_ARB_TIMEOUT_EN for the bench and the DUT together.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int MAX = 4;
    localparam int TMO = 16;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_valid, if_err;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_gnt, dm_valid, dm_err;
    logic [31:0] dm_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;

    mem_port_arbiter #(
        .MAX_DATA_STREAK (MAX),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_valid  (dm_valid),
        .dm_rdata  (dm_rdata),
        .dm_err    (dm_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model.
    // m_phase: 0 = no access, 1 = waiting for memory, 2 = reporting result.
    // ------------------------------------------------------------------
    bit          model_live = 1'b0;
    int          m_phase;
    bit          m_fetch;
    bit          m_store;
    int          m_wait;
    int          m_streak;
    logic        e_if_gnt, e_if_valid, e_if_err, e_dm_gnt, e_dm_valid, e_dm_err;
    logic        e_mem_req, e_mem_we, e_busy;
    logic [31:0] e_if_rdata, e_dm_rdata, e_mem_addr, e_mem_wdata;

    task automatic model_finish(input bit aborted, input logic [31:0] data);
        m_phase   = 2;
        e_mem_req = 1'b0;
        e_mem_we  = 1'b0;
        if (m_fetch) begin
            e_if_valid = 1'b1;
            e_if_err   = aborted;
            e_if_rdata = aborted ? 32'h0 : data;
        end else begin
            e_dm_valid = 1'b1;
            e_dm_err   = aborted;
            if (aborted)
                e_dm_rdata = 32'h0;
            else if (!m_store)
                e_dm_rdata = data;
        end
    endtask

    always @(posedge clock) begin
        if (reset) begin
            model_live = 1'b1;
            m_phase = 0; m_streak = 0; m_wait = 0; m_fetch = 0; m_store = 0;
            {e_if_gnt, e_if_valid, e_if_err, e_dm_gnt, e_dm_valid, e_dm_err} = '0;
            {e_mem_req, e_mem_we, e_busy} = '0;
            e_if_rdata = 0; e_dm_rdata = 0; e_mem_addr = 0; e_mem_wdata = 0;
        end else if (model_live) begin
            {e_if_gnt, e_if_valid, e_if_err, e_dm_gnt, e_dm_valid, e_dm_err} = '0;
            if (m_phase == 0) begin
                if (dm_req && (m_streak < MAX || !if_req)) begin
                    m_phase = 1; m_fetch = 0; m_store = dm_we; m_wait = 0;
                    e_dm_gnt = 1'b1; e_mem_req = 1'b1; e_mem_we = dm_we;
                    e_mem_addr = dm_addr & 32'hFFFF_FFFC; e_mem_wdata = dm_wdata;
                    m_streak = if_req ? ((m_streak + 1 > MAX) ? MAX : m_streak + 1) : 0;
                end else if (if_req) begin
                    m_phase = 1; m_fetch = 1; m_store = 0; m_wait = 0;
                    e_if_gnt = 1'b1; e_mem_req = 1'b1; e_mem_we = 1'b0;
                    e_mem_addr = if_addr & 32'hFFFF_FFFC; e_mem_wdata = 32'h0;
                    m_streak = 0;
                end
            end else if (m_phase == 1) begin
                m_wait++;
                if (mem_ready)
                    model_finish(1'b0, mem_rdata);
                else if (TMO_EN && m_wait >= TMO)
                    model_finish(1'b1, 32'h0);
            end else begin
                m_phase = 0;
            end
            e_busy = (m_phase != 0);
        end
    end

    always @(negedge clock) begin
        if (model_live) begin
            check("if_gnt", if_gnt, e_if_gnt);
            check("if_valid", if_valid, e_if_valid);
            check("if_rdata", if_rdata, e_if_rdata);
            check("if_err", if_err, e_if_err);
            check("dm_gnt", dm_gnt, e_dm_gnt);
            check("dm_valid", dm_valid, e_dm_valid);
            check("dm_rdata", dm_rdata, e_dm_rdata);
            check("dm_err", dm_err, e_dm_err);
            check("mem_req", mem_req, e_mem_req);
            check("mem_we", mem_we, e_mem_we);
            check("mem_addr", mem_addr, e_mem_addr);
            check("mem_wdata", mem_wdata, e_mem_wdata);
            check("busy", busy, e_busy);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int  n;
    bit  got_fetch;

    initial begin
        reset = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
        dm_addr = 0; dm_wdata = 0; mem_ready = 0; mem_rdata = 0;
        tick(); tick();
        check("reset_busy", busy, 0);
        check("reset_mem_req", mem_req, 0);
        check("reset_if_rdata", if_rdata, 0);
        reset = 1'b0;
        tick();

        // 1: single fetch, memory ready on the first BUSY cycle
        if_req = 1; if_addr = 32'h0040_0002;
        tick();
        check("t1_if_gnt", if_gnt, 1);
        check("t1_mem_addr", mem_addr, 32'h0040_0000);
        check("t1_mem_req", mem_req, 1);
        mem_ready = 1; mem_rdata = 32'h8C08_0004;
        tick();
        check("t1_if_valid", if_valid, 1);
        check("t1_if_rdata", if_rdata, 32'h8C08_0004);
        check("t1_if_gnt_low", if_gnt, 0);
        if_req = 0; mem_ready = 0;
        tick();
        check("t1_busy_low", busy, 0);
        check("t1_if_valid_low", if_valid, 0);

        // 2: simultaneous fetch and load, data first, then fetch
        if_req = 1; if_addr = 32'h0000_0100;
        dm_req = 1; dm_we = 0; dm_addr = 32'h0000_0010;
        tick();
        check("t2_dm_gnt", dm_gnt, 1);
        check("t2_if_gnt", if_gnt, 0);
        check("t2_mem_addr_d", mem_addr, 32'h0000_0010);
        mem_ready = 1; mem_rdata = 32'h1111_2222;
        tick();
        check("t2_dm_valid", dm_valid, 1);
        check("t2_dm_rdata", dm_rdata, 32'h1111_2222);
        dm_req = 0; mem_ready = 0;
        tick();
        tick();
        check("t2_if_gnt_after", if_gnt, 1);
        check("t2_mem_addr_i", mem_addr, 32'h0000_0100);
        mem_ready = 1; mem_rdata = 32'h2222_3333;
        tick();
        check("t2_if_valid", if_valid, 1);
        if_req = 0; mem_ready = 0;
        tick(); tick();

        // 3: continuous loads with a waiting fetch, streak bound twice
        mem_ready = 1; if_req = 1; if_addr = 32'h0000_1000;
        dm_req = 1; dm_we = 0; dm_addr = 32'h0000_0200;
        for (int round = 0; round < 2; round++) begin
            n = 0; got_fetch = 0;
            for (int c = 0; c < 40 && !got_fetch; c++) begin
                mem_rdata = 32'hA000_0000 + 32'(c) + 32'(round * 100);
                tick();
                if (dm_gnt) begin
                    n++;
                    dm_addr = 32'h0000_0200 + 32'(4 * n);
                end
                if (if_gnt) got_fetch = 1;
            end
            check("t3_fetch_granted", 32'(got_fetch), 1);
            check("t3_data_grants", 32'(n), MAX);
        end
        if_req = 0; dm_req = 0;
        tick(); tick(); tick();
        mem_ready = 0;
        check("t3_idle", busy, 0);

        // 4: load a known word, then a delayed store that must not touch it
        dm_req = 1; dm_we = 0; dm_addr = 32'h0000_0030;
        mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
        tick(); tick();
        check("t4_lw_rdata", dm_rdata, 32'hCAFE_F00D);
        dm_req = 0; mem_ready = 0;
        tick();
        dm_req = 1; dm_we = 1; dm_addr = 32'h0000_0022; dm_wdata = 32'hDEAD_BEEF;
        mem_rdata = 32'h5555_5555;
        tick();
        check("t4_sw_gnt", dm_gnt, 1);
        check("t4_sw_mem_we", mem_we, 1);
        check("t4_sw_mem_addr", mem_addr, 32'h0000_0020);
        dm_wdata = 32'h1234_5678; dm_addr = 32'h0000_0500;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_wdata_stable", mem_wdata, 32'hDEAD_BEEF);
            check("t4_we_stable", mem_we, 1);
            check("t4_no_valid_yet", dm_valid, 0);
        end
        mem_ready = 1;
        tick();
        check("t4_sw_valid", dm_valid, 1);
        check("t4_sw_rdata_kept", dm_rdata, 32'hCAFE_F00D);
        check("t4_we_dropped", mem_we, 0);
        dm_req = 0; dm_we = 0; mem_ready = 0;
        tick();
        check("t4_valid_one_pulse", dm_valid, 0);
        tick();

        // 5: reset in the middle of a data access
        dm_req = 1; dm_we = 0; dm_addr = 32'h0000_0040;
        tick();
        check("t5_dm_gnt", dm_gnt, 1);
        reset = 1; mem_ready = 1; mem_rdata = 32'h7777_7777;
        tick();
        check("t5_mem_req", mem_req, 0);
        check("t5_busy", busy, 0);
        check("t5_no_valid", dm_valid, 0);
        reset = 0; dm_req = 0; mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_never_valid", dm_valid, 0);
        end

        // 6: fetch with a memory that never answers
        if_req = 1; if_addr = 32'h0000_2000;
        tick();
        check("t6_if_gnt", if_gnt, 1);
`ifdef MEM_ARB_TIMEOUT_EN
        n = 0;
        for (int c = 0; c < 40 && !if_valid; c++) begin
            tick();
            n++;
        end
        check("t6_busy_cycles", 32'(n), TMO);
        check("t6_if_valid", if_valid, 1);
        check("t6_if_err", if_err, 1);
        check("t6_if_rdata", if_rdata, 0);
        if_req = 0; mem_ready = 1;
        tick();
        check("t6_stray_ready_busy", busy, 0);
        check("t6_stray_ready_valid", if_valid, 0);
        mem_ready = 0;
        tick();
`else
        for (int c = 0; c < 20; c++) begin
            tick();
            check("t6_busy_held", busy, 1);
        end
        check("t6_no_valid", if_valid, 0);
        if_req = 0; reset = 1;
        tick();
        reset = 0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
